// File: rtl/lsu_mem_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_if -- load/store memory interface for the MEM stage.
//
// Takes one load or store per request and rejects misaligned halfword/word
// accesses. Aligned requests are registered onto a single-port data SRAM.
// The SRAM has active-low per-byte write enables and store data that is
// replicated across the lanes. The block then waits for mem_ack. Load data is
// returned right-aligned: the addressed byte or halfword sits at bit 0.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   : an access that sees no mem_ack within 16 ACCESS cycles is
//               aborted and completes with bus_err=1 (load rdata cleared).
//   undefined : ACCESS waits indefinitely; bus_err is tied low.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/we/...    MEM-stage request (funct3 = RV32I width code)
//   req_ready           block idle, can accept
//   stall               hold the pipeline
//   resp_valid          one-cycle completion pulse
//   rdata               right-aligned load data, held until the next load
//   misalign_err        one-cycle pulse for a rejected misaligned request
//   bus_err             timeout abort flag, valid with resp_valid
//   mem_cs/oe/web/addr/di  SRAM control, registered
//   mem_do, mem_ack     SRAM read data and access-complete strobe
// -----------------------------------------------------------------------------
module lsu_mem_if #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              req_ready,
   output logic              stall,
   output logic              resp_valid,
   output logic [31:0]       rdata,
   output logic              misalign_err,
   output logic              bus_err,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic [3:0]        mem_web,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_di,
   input  logic [31:0]       mem_do,
   input  logic              mem_ack
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic                r_resp_valid;
   logic [31:0]         r_rdata;
   logic                r_misalign_err;
   logic                r_mem_cs;
   logic                r_mem_oe;
   logic [3:0]          r_mem_web;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_di;
   logic [1:0]          r_off;

   logic                w_is_b;
   logic                w_is_h;
   logic [1:0]          w_off;
   logic                w_misalign;
   logic                w_accept;
   logic                w_ack_done;
   logic                w_tmo_done;
   logic                w_tmo_hit;
   logic [3:0]          w_web;
   logic [31:0]         w_di;
   logic                w_unused;

   // Width decode: funct3[2] only selects sign/zero extension downstream.
   // Every code that is not B/BU or H/HU (including 011/110/111) is a word.
   assign w_is_b     = (req_funct3[1:0] == 2'b00);
   assign w_is_h     = (req_funct3[1:0] == 2'b01);
   assign w_off      = req_addr[1:0];
   assign w_misalign = w_is_h ? req_addr[0] : (!w_is_b && (req_addr[1:0] != 2'b00));
   assign w_accept   = req_valid && (r_state == IDLE) && !w_misalign;

   // Upper address bits and the extension bit of funct3 are not needed here.
   assign w_unused = &{1'b0, req_addr[31:ADDR_W+2], req_funct3[2]};

   // Store lane enables and replicated write data.
   always_comb begin
      w_web = 4'hF;
      w_di  = req_wdata;
      if (req_we) begin
         if (w_is_b) begin
            w_web = ~(4'b0001 << w_off);
            w_di  = {4{req_wdata[7:0]}};
         end else if (w_is_h) begin
            w_web = w_off[1] ? 4'b0011 : 4'b1100;
            w_di  = {2{req_wdata[15:0]}};
         end else begin
            w_web = 4'b0000;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state. A same-cycle ack takes priority over the timeout.
   always_comb begin
      w_state_next = r_state;
      w_ack_done   = 1'b0;
      w_tmo_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               w_ack_done   = 1'b1;
               w_state_next = IDLE;
            end else if (w_tmo_hit) begin
               w_tmo_done   = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Registered SRAM port, response pulses and load data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid   <= 1'b0;
         r_rdata        <= '0;
         r_misalign_err <= 1'b0;
         r_mem_cs       <= 1'b0;
         r_mem_oe       <= 1'b0;
         r_mem_web      <= 4'hF;
         r_mem_addr     <= '0;
         r_mem_di       <= '0;
         r_off          <= 2'b00;
      end else begin
         r_resp_valid   <= w_ack_done | w_tmo_done;
         r_misalign_err <= req_valid && (r_state == IDLE) && w_misalign;
         if (w_accept) begin
            r_mem_cs   <= 1'b1;
            r_mem_oe   <= !req_we;
            r_mem_web  <= w_web;
            r_mem_addr <= req_addr[ADDR_W+1:2];
            r_mem_di   <= w_di;
            r_off      <= w_off;
         end else if (w_ack_done || w_tmo_done) begin
            r_mem_cs  <= 1'b0;
            r_mem_oe  <= 1'b0;
            r_mem_web <= 4'hF;
         end
         // mem_oe doubles as the "this access is a load" flag.
         if (w_ack_done && r_mem_oe) begin
            r_rdata <= mem_do >> {r_off, 3'b000};
         end else if (w_tmo_done && r_mem_oe) begin
            r_rdata <= '0;
         end
      end
   end

`ifdef LSU_TIMEOUT_EN
   logic [3:0] r_tmo_cnt;
   logic       r_bus_err;

   // Counts ACCESS cycles from 0; value 15 marks the 16th ACCESS cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= 4'd0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_tmo_done;
         if (w_accept) begin
            r_tmo_cnt <= 4'd0;
         end else if (r_state == ACCESS) begin
            r_tmo_cnt <= r_tmo_cnt + 4'd1;
         end
      end
   end

   assign w_tmo_hit = (r_state == ACCESS) && (r_tmo_cnt == 4'hF);
   assign bus_err   = r_bus_err;
`else
   assign w_tmo_hit = 1'b0;
   assign bus_err   = 1'b0;
`endif

   assign req_ready    = (r_state == IDLE);
   assign stall        = (r_state == ACCESS) || ((r_state == IDLE) && req_valid && !w_misalign);
   assign resp_valid   = r_resp_valid;
   assign rdata        = r_rdata;
   assign misalign_err = r_misalign_err;
   assign mem_cs       = r_mem_cs;
   assign mem_oe       = r_mem_oe;
   assign mem_web      = r_mem_web;
   assign mem_addr     = r_mem_addr;
   assign mem_di       = r_mem_di;

endmodule

// File: tb/tb_lsu_mem_if.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_if -- scoreboard bench for lsu_mem_if.
// The stimulus pushes expected responses and expected SRAM accesses into queues.
// A responder acts as the SRAM and checks each access as it starts. A monitor
// pops and checks every resp_valid / misalign_err. The reference model is a
// byte-addressed memory updated with RV32I store semantics.
// -----------------------------------------------------------------------------
module tb_lsu_mem_if;

   localparam int NO_ACK = 99;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        stall;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        misalign_err;
   logic        bus_err;
   logic        mem_cs;
   logic        mem_oe;
   logic [3:0]  mem_web;
   logic [13:0] mem_addr;
   logic [31:0] mem_di;
   logic [31:0] mem_do;
   logic        mem_ack;

   lsu_mem_if #(.ADDR_W(14)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid),
      .rdata(rdata), .misalign_err(misalign_err), .bus_err(bus_err),
      .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web),
      .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do), .mem_ack(mem_ack)
   );

   typedef struct {
      bit          is_mis;
      logic [31:0] data;
      bit          berr;
      bit          tmo;
      int          acc_cyc;
   } resp_t;

   typedef struct {
      logic [13:0] addr;
      logic [3:0]  web;
      logic [31:0] di;
      bit          is_store;
      bit          oe;
      int          dly;
   } acc_t;

   resp_t       exp_q[$];
   acc_t        acc_q[$];
   logic [7:0]  refmem [0:63];
   logic [31:0] sram [0:15];
   logic [31:0] held;
   int          checks;
   int          errors;
   int          cyc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   // One request: wait for idle, drive for one cycle, push expectations.
   task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int dly);
      int          n;
      int          sz;
      int          off;
      int          base;
      bit          ok;
      resp_t       e;
      acc_t        a;
      logic [31:0] ld;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_wait", 64'(req_ready), 64'd1);
         return;
      end
      sz   = size_of(f3);
      off  = int'(addr[1:0]);
      base = int'({addr[5:2], 2'b00});
      ok   = (off % sz) == 0;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      #1;
      chk("stall_on_req", 64'(stall), 64'(ok));
      e.is_mis  = !ok;
      e.data    = held;
      e.berr    = 1'b0;
      e.tmo     = 1'b0;
      e.acc_cyc = cyc;
      if (ok) begin
         a.addr     = addr[15:2];
         a.is_store = we;
         a.oe       = !we;
         a.dly      = dly;
         a.web      = 4'hF;
         a.di       = '0;
         for (int i = 0; i < 4; i++) begin
            if (we && i >= off && i < off + sz) a.web[i] = 1'b0;
            a.di[8*i +: 8] = 8'((wd >> (8 * (i % sz))) & 32'hFF);
         end
         if (we) begin
            for (int i = 0; i < sz; i++) refmem[base + off + i] = 8'((wd >> (8 * i)) & 32'hFF);
         end else begin
            ld = '0;
            for (int i = off; i < 4; i++) ld = ld | (32'(refmem[base + i]) << (8 * (i - off)));
            e.data = ld;
         end
         if (dly == NO_ACK) begin
            e.berr = 1'b1;
            e.tmo  = 1'b1;
            if (!we) e.data = '0;
         end
         held = e.data;
         acc_q.push_back(a);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (!ok) begin
         @(negedge clk);
         chk("misalign_no_access", 64'({mem_cs, stall, req_ready}), 64'(3'b001));
      end
   endtask

   task automatic chk_reset_state(input string name);
      chk(name, {req_ready, stall, mem_cs, mem_oe, mem_web, mem_addr, mem_di, rdata[7:0],
                 resp_valid, misalign_err, bus_err},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 14'h0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0});
      chk({name, "_rdata"}, 64'(rdata), 64'd0);
   endtask

   // SRAM responder: checks each access, acks after the requested delay.
   initial begin : responder
      acc_t        a;
      int          w;
      bit          aborted;
      logic [50:0] snap;
      logic [3:0]  web_s;
      logic [31:0] di_s;
      logic [3:0]  idx_s;
      mem_ack = 1'b0;
      mem_do  = '0;
      forever begin
         @(negedge clk);
         if (!(rst_n && mem_cs)) begin
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_do  = $urandom;
            continue;
         end
         mem_ack = 1'b0;
         if (acc_q.size() == 0) begin
            chk("unexpected_access", 64'(mem_cs), 64'd0);
            w = 0;
            while (mem_cs && w < 40) begin
               @(negedge clk);
               w++;
            end
            continue;
         end
         a = acc_q.pop_front();
         chk("acc_addr", 64'(mem_addr), 64'(a.addr));
         chk("acc_web", 64'(mem_web), 64'(a.web));
         chk("acc_oe", 64'(mem_oe), 64'(a.oe));
         chk("acc_stall", 64'({stall, req_ready}), 64'(2'b10));
         if (a.is_store) chk("acc_di", 64'(mem_di), 64'(a.di));
         if (a.dly == NO_ACK) begin
            w = 0;
            while (mem_cs && w < 40) begin
               @(negedge clk);
               w++;
            end
            chk("no_ack_release", 64'(mem_cs), 64'd0);
            continue;
         end
         snap    = {mem_addr, mem_web, mem_oe, mem_di};
         aborted = 1'b0;
         for (int i = 0; i < a.dly; i++) begin
            @(negedge clk);
            if (!mem_cs) begin
               aborted = 1'b1;
               break;
            end
            chk("acc_hold", 64'({mem_addr, mem_web, mem_oe, mem_di} ^ snap), 64'd0);
         end
         if (aborted) continue;
         web_s = mem_web;
         di_s  = mem_di;
         idx_s = mem_addr[3:0];
         mem_do  = mem_oe ? sram[idx_s] : $urandom;
         mem_ack = 1'b1;
         @(posedge clk);
         for (int i = 0; i < 4; i++) begin
            if (!web_s[i]) sram[idx_s][8*i +: 8] = di_s[8*i +: 8];
         end
         #1;
         mem_ack = 1'b0;
         mem_do  = $urandom;
         @(negedge clk);
         chk("resp_latency", 64'({resp_valid, mem_cs, mem_web}), 64'({1'b1, 1'b0, 4'hF}));
      end
   end

   // Monitor: pops one expectation per response pulse.
   initial begin : monitor
      resp_t e;
      forever begin
         @(negedge clk);
         if (bus_err && !resp_valid) chk("bus_err_stray", 64'(bus_err), 64'd0);
         if (resp_valid || misalign_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", 64'({resp_valid, misalign_err}), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_kind", 64'({resp_valid, misalign_err}), 64'({!e.is_mis, e.is_mis}));
               if (!e.is_mis) begin
                  chk("rdata", 64'(rdata), 64'(e.data));
                  chk("bus_err", 64'(bus_err), 64'(e.berr));
                  if (e.tmo) chk("tmo_latency", 64'(cyc - e.acc_cyc), 64'd17);
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [2:0]  st_codes [0:5];
      logic [2:0]  f3;
      logic [31:0] addr;
      bit          we;
      int          n;
      int          sz;
      st_codes[0] = 3'd0; st_codes[1] = 3'd1; st_codes[2] = 3'd2;
      st_codes[3] = 3'd3; st_codes[4] = 3'd6; st_codes[5] = 3'd7;
      checks = 0;
      errors = 0;
      held   = '0;
      for (int i = 0; i < 64; i++) refmem[i] = 8'($urandom);
      for (int i = 0; i < 16; i++)
         sram[i] = {refmem[4*i+3], refmem[4*i+2], refmem[4*i+1], refmem[4*i]};
      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk_reset_state("reset_values");
      rst_n = 1'b1;

      // Directed cases.
      issue(1'b1, 3'b010, 32'h0000_1000, 32'h8899_AABB, 0);
      issue(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0);          // LB -> 0x88
      issue(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 2);  // SH upper half
      issue(1'b0, 3'b010, 32'h0000_0006, 32'h0, 0);          // misaligned LW
      issue(1'b1, 3'b010, 32'h0000_0010, $urandom, 4);       // ack at cycle 5
      issue(1'b0, 3'b010, 32'h0000_0014, 32'h0, 1);          // back-to-back LW
      issue(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0);          // LHU sees SH data

      // Reset in cycle 2 of a pending load.
      issue(1'b0, 3'b010, 32'h0000_0020, 32'h0, NO_ACK);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_state("reset_mid_access");
      void'(exp_q.pop_back());
      held = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

`ifdef LSU_TIMEOUT_EN
      issue(1'b0, 3'b000, 32'h0000_0004, 32'h0, 0);  // non-zero rdata first
      issue(1'b0, 3'b010, 32'h0000_0024, 32'h0, NO_ACK);
`endif

      // Randomised traffic.
      for (int t = 0; t < 300; t++) begin
         we = 1'($urandom_range(0, 1));
         f3 = we ? st_codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
         sz = size_of(f3);
         addr = $urandom;
         if ($urandom_range(0, 9) != 0) addr = addr & ~32'(sz - 1);
         issue(we, f3, addr, $urandom, int'($urandom_range(0, 5)));
      end

      n = 0;
      while ((exp_q.size() != 0 || acc_q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(exp_q.size() + acc_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
